mem_arbiter: RTL
================

# mem_arbiter

Shares the single-port unified memory between the IF stage (instruction fetch) and the MEM stage (data load/store, driven by the decoded MemRead/MemWrite controls). It sequences one memory transaction at a time through a request/done handshake with each requester. It produces the stall signals the pipeline uses while a requester waits, and it bounds every transaction with a timeout.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- TIMEOUT, 16, maximum WAIT cycles before a transaction is abandoned (≥2)
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- i_req  in  1  fetch request; held high until i_done
- i_addr  in  ADDR_W  fetch address; stable while i_req is high
- i_done  out  1  one-cycle pulse; i_rdata is valid in this cycle
- i_rdata  out  DATA_W  fetched instruction (registered)
- d_req  in  1  data request (MemRead|MemWrite); held high until d_done
- d_we  in  1  1 = store, 0 = load; stable while d_req is high
- d_addr, d_wdata  in  ADDR_W / DATA_W  data address and store data
- d_done  out  1  one-cycle pulse; d_rdata is valid in this cycle
- d_rdata  out  DATA_W  load data (registered)
- mem_en  out  1  one-cycle command strobe to memory
- mem_we  out  1  write enable, qualified by mem_en
- mem_addr, mem_wdata  out  ADDR_W / DATA_W  registered command fields
- mem_valid  in  1  memory completion pulse (read data or write ack)
- mem_rdata  in  DATA_W  read data, valid with mem_valid
- if_stall  out  1  i_req & ~i_done (combinational)
- d_stall  out  1  d_req & ~d_done (combinational)
- err  out  1  sticky timeout flag; cleared only by rst

## Operation
- States: IDLE, WAIT_I, WAIT_D, RESP.
- IDLE, d_req=1 → WAIT_D. Latch d_we/d_addr/d_wdata into the mem_* registers. d_req has priority over i_req when both are high.
- IDLE, i_req=1 only → WAIT_I. mem_we=0, mem_addr=i_addr.
- IDLE, no request → stay in IDLE. mem_valid is ignored in IDLE and RESP.
- mem_en is high only in the first cycle of WAIT_I/WAIT_D. mem_addr, mem_we and mem_wdata hold their values for the whole WAIT.
- WAIT_x, mem_valid=1 → RESP:
  - Capture mem_rdata into i_rdata (WAIT_I) or d_rdata (WAIT_D).
  - For a store, d_rdata is unchanged.
- Timeout counter:
  - Cleared on entry to WAIT and incremented each WAIT cycle without mem_valid.
  - If the counter equals TIMEOUT-1 and mem_valid=0 → RESP with err←1.
  - On a fetch timeout, i_rdata←16'hF000 (HLT), which halts the core. On a data timeout, d_rdata←0.
  - If mem_valid arrives on the last allowed cycle, it completes the transaction normally.
- RESP: pulse i_done or d_done (whichever was served) for one cycle, then go to IDLE.
- Requesters deassert req, or present a new request, in the cycle after done. A new request is accepted in the following IDLE.
- At most one transaction is outstanding. Requests are never dropped. A losing requester stays stalled until it is served.
- Reset mid-operation:
  - The FSM returns to IDLE immediately.
  - Any in-flight mem_valid arriving later is ignored.
  - No done pulse is generated for the aborted transaction.

## Timing
- Reset values: state=IDLE; i_done=d_done=mem_en=mem_we=err=0; mem_addr=mem_wdata=i_rdata=d_rdata=0.
- Request sampled high in IDLE at cycle N → mem_en high in cycle N+1.
- mem_valid in cycle M (M ≥ N+1) → done high in cycle M+1, IDLE in cycle M+2.
- Minimum request-to-done latency: 2 cycles. Minimum gap between consecutive mem_en strobes: 3 cycles.
- Timeout: WAIT lasts at most TIMEOUT cycles. done and err rise in the same cycle.
- if_stall/d_stall fall in the done cycle itself.

## Test plan
- **Reset:** assert rst asynchronously mid-cycle → all outputs 0 immediately; err=0; state IDLE.
- **Single fetch:**
  - Stimulus: i_req=1, i_addr=0x0010; mem_valid with mem_rdata=0xB123 two cycles after mem_en.
  - Required: one mem_en cycle with mem_we=0 and mem_addr=0x0010; i_done pulses one cycle after mem_valid with i_rdata=0xB123; if_stall high until then.
- **Simultaneous requests:**
  - Stimulus: i_req (0x0020) and d_req (store, d_addr=0x8000, d_wdata=0x1234) raised in the same cycle.
  - Required: the first mem_en carries mem_we=1, 0x8000, 0x1234; after d_done the fetch is issued to 0x0020; if_stall stays high throughout.
- **Timeout:** TIMEOUT=8, fetch issued, mem_valid never arrives → after 8 WAIT cycles i_done=1 with i_rdata=0xF000; err=1 and stays 1 across later transactions.
- **Reset mid-transaction:** rst pulsed during WAIT_D, then mem_valid 2 cycles later → no d_done; FSM in IDLE; no new mem_en unless a request is present.
- **Back-to-back loads:**
  - Stimulus: a second d_req presented in the cycle after d_done, with a new address.
  - Required: a new mem_en 2 cycles after d_done; the earlier d_rdata is held until the new capture.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Serialises IF fetches and MEM loads/stores onto one memory port,
//            with per-requester stalls and a bounded wait per transaction.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    // instruction fetch port
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [DATA_W-1:0] i_rdata,
    // data load/store port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    // memory command / response
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    // pipeline status
    output logic              if_stall,
    output logic              d_stall,
    output logic              err
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [CNT_W-1:0]  c_cnt_last = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  c_cnt_one  = CNT_W'(1);
    localparam logic [DATA_W-1:0] c_hlt_word = DATA_W'(16'hF000);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT_I = 2'd1,
        S_WAIT_D = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_sel_d;     // 1 while the data port owns the transaction
    logic [CNT_W-1:0]  r_cnt;

    logic              w_start_i;
    logic              w_start_d;
    logic              w_complete;
    logic              w_timeout;
    logic              w_in_wait;

    assign w_in_wait = (r_state == S_WAIT_I) || (r_state == S_WAIT_D);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next     = r_state;
        w_start_i  = 1'b0;
        w_start_d  = 1'b0;
        w_complete = 1'b0;
        w_timeout  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (d_req) begin
                    w_next    = S_WAIT_D;
                    w_start_d = 1'b1;
                end else if (i_req) begin
                    w_next    = S_WAIT_I;
                    w_start_i = 1'b1;
                end
            end
            S_WAIT_I, S_WAIT_D: begin
                // A response on the final allowed cycle wins over the timeout
                if (mem_valid) begin
                    w_next     = S_RESP;
                    w_complete = 1'b1;
                end else if (r_cnt == c_cnt_last) begin
                    w_next    = S_RESP;
                    w_timeout = 1'b1;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, command and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_sel_d   <= 1'b0;
            r_cnt     <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            err       <= 1'b0;
        end else begin
            r_state <= w_next;
            mem_en  <= w_start_i | w_start_d;

            if (w_start_d) begin
                r_sel_d   <= 1'b1;
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
            end else if (w_start_i) begin
                r_sel_d  <= 1'b0;
                mem_we   <= 1'b0;
                mem_addr <= i_addr;
            end

            if (w_start_i || w_start_d) begin
                r_cnt <= '0;
            end else if (w_in_wait && !mem_valid && (r_cnt != c_cnt_last)) begin
                r_cnt <= r_cnt + c_cnt_one;
            end

            if (w_complete) begin
                if (!r_sel_d) begin
                    i_rdata <= mem_rdata;
                end else if (!mem_we) begin
                    d_rdata <= mem_rdata;
                end
            end

            // An abandoned fetch returns HLT so the core stops cleanly
            if (w_timeout) begin
                err <= 1'b1;
                if (r_sel_d) begin
                    d_rdata <= '0;
                end else begin
                    i_rdata <= c_hlt_word;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Handshake and stall outputs
    // ------------------------------------------------------------------
    assign i_done   = (r_state == S_RESP) && !r_sel_d;
    assign d_done   = (r_state == S_RESP) &&  r_sel_d;
    assign if_stall = i_req & ~i_done;
    assign d_stall  = d_req & ~d_done;

endmodule
`default_nettype wire
